add_seq: RTL and testbench

//   Multi-cycle N-bit adder/subtractor: processes operands D bits per cycle, least

---
 rtl/add_seq_pkg.sv | 18 +
 rtl/add_seq_rca.sv | 40 ++++
 rtl/add_seq.sv | 108 ++++++++++
 tb/tb_add_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared encodings and sizing helpers for the digit-serial adder/subtractor.
package add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Digit counter width; a single-digit build still needs a 1-bit counter.
    function automatic int cnt_w(input int n, input int d);
        return (n / d > 1) ? $clog2(n / d) : 1;
    endfunction

endpackage

// File: rtl/add_seq_rca.sv
// One-bit full adder cell and the D-bit ripple-carry chain built from it.
module add_1bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module add_rca #(
    parameter int D = 4
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [D:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < D; i++) begin : g_bit
        add_1bit u_bit (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[D];
    // Carry into the top bit of the digit; on the last digit this is the carry into bit N-1.
    assign c_msb = c[D-1];
endmodule

// File: rtl/add_seq.sv
// Digit-serial N-bit adder/subtractor, D bits per cycle, LSD first, behind a
// 4-phase req/ack handshake.
module add_seq
    import add_seq_pkg::*;
#(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic         op,
    input  logic         ci,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         ack,
    output logic         busy,
    output logic [N-1:0] r,
    output logic         co,
    output logic         ov
);
    localparam int             CW       = cnt_w(N, D);
    localparam int             NDIG     = N / D;
    localparam logic [CW-1:0]  LAST_CNT = CW'(NDIG - 1);

    state_t         state;
    logic [N-1:0]   xs;
    logic [N-1:0]   ys;
    logic [N-1:0]   acc;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic [D-1:0]   dig_s;
    logic           dig_co;
    logic           dig_cmsb;
    logic [N-1:0]   next_acc;

    add_rca #(.D(D)) u_rca (
        .x     (xs[D-1:0]),
        .y     (ys[D-1:0]),
        .ci    (carry),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the top; after NDIG digits the full sum is aligned.
    assign next_acc = N'({dig_s, acc} >> D);

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
            r     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
            xs    <= '0;
            ys    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        xs    <= x;
                        ys    <= (op == OP_SUB) ? ~y : y;
                        carry <= (op == OP_SUB) ? ~ci : ci;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else begin
                        xs    <= xs >> D;
                        ys    <= ys >> D;
                        acc   <= next_acc;
                        carry <= dig_co;
                        if (cnt == LAST_CNT) begin
                            r     <= next_acc;
                            co    <= dig_co;
                            ov    <= dig_cmsb ^ dig_co;
                            ack   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ack   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench: D=4, D=1 and D=16 builds run side by side on shared stimulus.
module tb_add_seq;

    typedef struct {
        logic [15:0] r;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        op = 1'b0;
    logic        ci = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;

    logic [2:0]  ack_v;
    logic [2:0]  busy_v;
    logic [2:0]  co_v;
    logic [2:0]  ov_v;
    logic [15:0] r_v [3];

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    logic [15:0] last_r = '0;
    localparam int LAT [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    add_seq #(.N(16), .D(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .ci(ci), .x(x), .y(y),
        .ack(ack_v[0]), .busy(busy_v[0]), .r(r_v[0]), .co(co_v[0]), .ov(ov_v[0])
    );
    add_seq #(.N(16), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .ci(ci), .x(x), .y(y),
        .ack(ack_v[1]), .busy(busy_v[1]), .r(r_v[1]), .co(co_v[1]), .ov(ov_v[1])
    );
    add_seq #(.N(16), .D(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .ci(ci), .x(x), .y(y),
        .ack(ack_v[2]), .busy(busy_v[2]), .r(r_v[2]), .co(co_v[2]), .ov(ov_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic op_i, input logic ci_i,
                                   input logic [15:0] x_i, input logic [15:0] y_i);
        exp_t e;
        logic [16:0] s;
        if (op_i) s = {1'b0, x_i} + {1'b0, ~y_i} + 17'(!ci_i);
        else      s = {1'b0, x_i} + {1'b0, y_i} + 17'(ci_i);
        e.r  = s[15:0];
        e.co = s[16];
        if (op_i) e.ov = (x_i[15] != y_i[15]) && (e.r[15] != x_i[15]);
        else      e.ov = (x_i[15] == y_i[15]) && (e.r[15] != x_i[15]);
        return e;
    endfunction

    task automatic run_op(input logic op_i, input logic ci_i, input logic [15:0] x_i,
                          input logic [15:0] y_i, input int hold);
        exp_t e;
        int lat [3];
        op = op_i; ci = ci_i; x = x_i; y = y_i; req = 1'b1;
        exp_q.push_back(model(op_i, ci_i, x_i, y_i));
        @(posedge clk); #1;
        // Operands must only be sampled on the load edge.
        x = ~x_i; y = ~y_i; op = ~op_i; ci = ~ci_i;
        chk("busy_after_load", busy_v[0], 1'b1);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (lat[i] < 0 && ack_v[i]) lat[i] = k;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        e = exp_q.pop_front();
        last_r = e.r;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lat[%0d]", i), lat[i], LAT[i]);
            chk($sformatf("r[%0d]", i), r_v[i], e.r);
            chk($sformatf("co[%0d]", i), co_v[i], e.co);
            chk($sformatf("ov[%0d]", i), ov_v[i], e.ov);
        end
        chk("busy_in_done", busy_v[0], 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("ack_hold", ack_v[0], 1'b1);
            chk("r_hold", r_v[0], e.r);
        end
        req = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) chk($sformatf("ack_fall[%0d]", i), ack_v[i], 1'b0);
    endtask

    initial begin
        logic [33:0] tbl [6];
        tbl[0] = {1'b0, 1'b0, 16'h1234, 16'h0FFF};
        tbl[1] = {1'b0, 1'b0, 16'hFFFF, 16'h0001};
        tbl[2] = {1'b0, 1'b0, 16'h7FFF, 16'h0001};
        tbl[3] = {1'b1, 1'b0, 16'h0005, 16'h0007};
        tbl[4] = {1'b1, 1'b0, 16'h8000, 16'h0001};
        tbl[5] = {1'b1, 1'b1, 16'h0010, 16'h0001};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack_v[0], 1'b0);
        chk("rst_busy", busy_v[0], 1'b0);
        chk("rst_r", r_v[0], 16'h0000);
        chk("rst_co", co_v[0], 1'b0);
        chk("rst_ov", ov_v[0], 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++)
            run_op(tbl[t][33], tbl[t][32], tbl[t][31:16], tbl[t][15:0], (t == 5) ? 5 : 0);

        // Abort: req dropped after two RUN edges.
        op = 1'b0; ci = 1'b0; x = 16'hAAAA; y = 16'h1111; req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_ack", ack_v[0], 1'b0);
        end
        req = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack", ack_v[0], 1'b0);
        chk("abort_busy", busy_v[0], 1'b0);
        chk("abort_r", r_v[0], last_r);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN.
        op = 1'b0; ci = 1'b0; x = 16'h0F0F; y = 16'h0101; req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_pre", busy_v[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", ack_v[0], 1'b0);
        chk("mid_rst_busy", busy_v[0], 1'b0);
        chk("mid_rst_r", r_v[0], 16'h0000);
        chk("mid_rst_co", co_v[0], 1'b0);
        chk("mid_rst_ov", ov_v[0], 1'b0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 1000; n++)
            run_op(1'($urandom_range(1)), 1'($urandom_range(1)),
                   16'($urandom), 16'($urandom), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
